// File: rtl/bullet_controller.sv
// Player bullet position generator: launch on fire, step upward on frame ticks, retire on top exit or hit.
// All outputs registered, one-cycle latency from fire/frame_tick/hit; no backpressure, inputs sampled every clk.
module bullet_controller #(
  parameter int TICKS_PER_STEP = 2,
  parameter int STEP_SIZE      = 1,
  parameter int Y_START        = 110,
  parameter int X_OFFSET       = 3,
  parameter int MAX_X          = 126,
  parameter int COOLDOWN_TICKS = 4,
  parameter int PARK_XY        = 127
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       fire,
  input  logic       frame_tick,
  input  logic [6:0] player_x,
  input  logic       hit,
  output logic [6:0] x,
  output logic [6:0] y,
  output logic       active,
  output logic       launched
);

  localparam int TW = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
  localparam int CW = (COOLDOWN_TICKS > 0) ? $clog2(COOLDOWN_TICKS + 1) : 1;
  localparam logic [6:0] PARK  = 7'(PARK_XY);
  localparam logic [6:0] STEP7 = 7'(STEP_SIZE);

  typedef enum logic [1:0] {IDLE, FLYING, COOLDOWN} state_t;

  state_t          state, state_n;
  logic [TW-1:0]   tick_cnt, tick_n;
  logic [CW-1:0]   cool_cnt, cool_n;
  logic [6:0]      x_n, y_n;
  logic            active_n, launched_n;
  logic            retire;
  logic [7:0]      x_sum;
  logic [6:0]      launch_x;

  // Eight-bit sum so a ship near the right edge clamps instead of wrapping.
  assign x_sum    = {1'b0, player_x} + 8'(X_OFFSET);
  assign launch_x = (x_sum > 8'(MAX_X)) ? 7'(MAX_X) : x_sum[6:0];

  always_comb begin
    state_n    = state;
    tick_n     = tick_cnt;
    cool_n     = cool_cnt;
    x_n        = x;
    y_n        = y;
    active_n   = active;
    launched_n = 1'b0;
    retire     = 1'b0;
    case (state)
      IDLE: begin
        if (fire) begin
          state_n    = FLYING;
          active_n   = 1'b1;
          launched_n = 1'b1;
          x_n        = launch_x;
          y_n        = 7'(Y_START);
          tick_n     = '0;
        end
      end
      FLYING: begin
        if (hit) begin
          retire = 1'b1;
        end else if (frame_tick) begin
          if (tick_cnt == TW'(TICKS_PER_STEP - 1)) begin
            tick_n = '0;
            // Leaving the top edge retires rather than letting y underflow.
            if (y < STEP7) retire = 1'b1;
            else           y_n = y - STEP7;
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end
      end
      COOLDOWN: begin
        if (frame_tick) begin
          cool_n = cool_cnt - 1'b1;
          if (cool_cnt == CW'(1)) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (retire) begin
      active_n = 1'b0;
      x_n      = PARK;
      y_n      = PARK;
      if (COOLDOWN_TICKS == 0) begin
        state_n = IDLE;
      end else begin
        state_n = COOLDOWN;
        cool_n  = CW'(COOLDOWN_TICKS);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      tick_cnt <= '0;
      cool_cnt <= '0;
      x        <= PARK;
      y        <= PARK;
      active   <= 1'b0;
      launched <= 1'b0;
    end else begin
      state    <= state_n;
      tick_cnt <= tick_n;
      cool_cnt <= cool_n;
      x        <= x_n;
      y        <= y_n;
      active   <= active_n;
      launched <= launched_n;
    end
  end

endmodule
